bithub_link_session_ctrl: RTL and testbench
===========================================

// Module: bithub_link_session_ctrl
// PURPOSE
//  Session sequencer for the governed secure link. Drives the identity/key handshake towards the
//  HSM, issues link_en (the link's policy enable) only once a session is established, forces
//  rekey on packet budget or request, zeroizes keys on every teardown, and latches a lockout fault
//  on handshake retry exhaustion or replay flood. All state is visible on outputs.
// PARAMETERS
//  TIMEOUT_CYC   1024   cycles allowed per handshake phase (ATTEST, KEYREQ, REKEY) before retry
//  MAX_RETRY     3      handshake timeouts tolerated per establishment; MAX_RETRY-th timeout -> LOCKOUT
//  REKEY_PKTS    65536  TX packets per session before forced rekey (>=2)
//  REPLAY_LIMIT  8      replay events per session that trigger LOCKOUT (>=1)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  gov_enable   in   1   policy permit; low tears down any non-LOCKOUT session
//  id_ok        in   1   HSM: identity attested (level)
//  key_ok       in   1   HSM: session key provisioned (level)
//  tx_pkt_done  in   1   one-cycle pulse per TX packet completed on the link
//  replay_evt   in   1   one-cycle pulse per replay blocked by the link
//  rekey_force  in   1   one-cycle pulse: host requests rekey (honoured in ACTIVE only)
//  clear_fault  in   1   one-cycle pulse: releases LOCKOUT (honoured only while gov_enable=0)
//  id_req       out  1   request attestation (high in ATTEST)
//  key_req      out  1   request session key (high in KEYREQ)
//  key_zeroize  out  1   one-cycle pulse: HSM must discard session key
//  link_en      out  1   link permitted to carry traffic (high in ACTIVE only)
//  fault        out  1   lockout latched (high in LOCKOUT)
//  state        out  3   current FSM state encoding
//  retry_cnt    out  2   timeouts in current establishment attempt
//  sess_cnt     out  16  sessions established since reset, wraps mod 2^16
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; internal timer, pkt and replay counters 0. Reset mid-handshake
//    drops id_req/key_req next cycle; no zeroize pulse on reset (HSM is reset with the link).
//  - States: IDLE=0 ATTEST=1 KEYREQ=2 ACTIVE=3 REKEY=4 LOCKOUT=5; 6,7 illegal -> LOCKOUT.
//  - All outputs registered; an input seen in cycle N affects outputs in cycle N+1.
//  - IDLE: gov_enable=1 -> ATTEST, timer=0, retry_cnt=0.
//  - ATTEST: id_ok=1 -> KEYREQ, timer=0. timer==TIMEOUT_CYC-1 -> retry_cnt+1; if new value==MAX_RETRY
//    -> LOCKOUT, else stay in ATTEST with timer=0.
//  - KEYREQ: key_ok=1 -> ACTIVE, sess_cnt+1, retry_cnt=0, pkt/replay counters=0. Timeout as ATTEST.
//    id_ok drop -> ATTEST (timer=0).
//  - ACTIVE, priority high->low: replay counter reaching REPLAY_LIMIT -> LOCKOUT; id_ok=0 -> ATTEST
//    + zeroize; key_ok=0 -> KEYREQ (no zeroize, key already gone); pkt_cnt reaching REKEY_PKTS or
//    rekey_force -> REKEY + zeroize.
//    tx_pkt_done and replay_evt in same cycle: both counted, replay-limit check wins.
//  - REKEY: link_en=0; waits key_ok=0 -> KEYREQ (timer=0, retry_cnt=0); timeout -> LOCKOUT.
//  - LOCKOUT: fault=1, all requests 0. clear_fault & ~gov_enable -> IDLE (fault=0); clear_fault
//    while gov_enable=1 ignored.
//  - gov_enable=0 in ATTEST/KEYREQ/ACTIVE/REKEY -> IDLE next cycle; overrides all other transitions;
//    zeroize pulse if leaving KEYREQ, ACTIVE or REKEY.
//  - key_zeroize: exactly one cycle per qualifying transition, including every entry to LOCKOUT
//    from KEYREQ, ACTIVE or REKEY; never asserted two consecutive cycles.
//  - Widths: timer $clog2(TIMEOUT_CYC); pkt counter $clog2(REKEY_PKTS+1); replay $clog2(REPLAY_LIMIT+1);
//    no counter wraps inside a session (transition fires first).
// STRUCTURE
//  - Shared package bithub_link_pkg: state enum/localparams (IDLE..LOCKOUT), state width.
//  - Single module; optional sub-module bithub_phase_timer (load/clear, terminal-count pulse),
//    reused for all handshake phases.
// TESTING
//  1 gov_enable=1, id_ok at +5, key_ok at +10 -> ATTEST, KEYREQ, ACTIVE; link_en=1; sess_cnt=1.
//  2 TIMEOUT_CYC=16, id_ok never -> retry_cnt 1,2 at cycles 16,32; LOCKOUT at 48; fault=1.
//  3 REKEY_PKTS=4, 4 tx_pkt_done pulses in ACTIVE -> REKEY, one zeroize pulse; key_ok drop, reassert
//    -> ACTIVE, sess_cnt=2.
//  4 REPLAY_LIMIT=2, replay_evt+tx_pkt_done same cycle twice -> LOCKOUT (not REKEY), zeroize 1 cycle.
//  5 gov_enable=0 in ACTIVE concurrent with rekey_force -> IDLE, link_en=0, single zeroize pulse.
//  6 LOCKOUT: clear_fault with gov_enable=1 ignored; clear_fault with gov_enable=0 -> IDLE, fault=0;
//    rst asserted in KEYREQ -> all outputs 0 next cycle, no zeroize.

Source files
------------

// File: rtl/bithub_link_pkg.sv
// bithub_link_pkg: shared state encoding for the link session controller
package bithub_link_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_ATTEST  = 3'd1,
    S_KEYREQ  = 3'd2,
    S_ACTIVE  = 3'd3,
    S_REKEY   = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;
endpackage

// File: rtl/bithub_phase_timer.sv
// bithub_phase_timer: free-running phase timer with clear and terminal-count flag
module bithub_phase_timer #(
  parameter int CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);
  localparam int W = $clog2(CYC);
  logic [W-1:0] cnt;
  // count cycles spent in the current phase, restarting on clear
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else cnt <= cnt + W'(1);
  assign tc = cnt == W'(CYC - 1);
endmodule

// File: rtl/bithub_link_session_ctrl.sv
// bithub_link_session_ctrl: session sequencer gating the secure link on HSM handshake state
import bithub_link_pkg::*;
module bithub_link_session_ctrl #(
  parameter int TIMEOUT_CYC  = 1024,
  parameter int MAX_RETRY    = 3,
  parameter int REKEY_PKTS   = 65536,
  parameter int REPLAY_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gov_enable,
  input  logic        id_ok,
  input  logic        key_ok,
  input  logic        tx_pkt_done,
  input  logic        replay_evt,
  input  logic        rekey_force,
  input  logic        clear_fault,
  output logic        id_req,
  output logic        key_req,
  output logic        key_zeroize,
  output logic        link_en,
  output logic        fault,
  output logic [2:0]  state,
  output logic [1:0]  retry_cnt,
  output logic [15:0] sess_cnt
);
  localparam int PW = $clog2(REKEY_PKTS + 1);
  localparam int RW = $clog2(REPLAY_LIMIT + 1);
  state_t st, st_nxt;
  logic tmr_tc, tmr_clr, retry_hit, sess_inc, zq, clr_cnt;
  logic [1:0] retry_nxt, retry_inc;
  logic [PW-1:0] pkt_cnt, pkt_inc;
  logic [RW-1:0] rpl_cnt, rpl_inc;
  assign retry_inc = retry_cnt + 2'd1;
  assign retry_hit = retry_inc == 2'(MAX_RETRY);
  assign pkt_inc = pkt_cnt + PW'(tx_pkt_done);
  assign rpl_inc = rpl_cnt + RW'(replay_evt);
  assign tmr_clr = (st_nxt != st) || tmr_tc;
  bithub_phase_timer #(.CYC(TIMEOUT_CYC)) u_tmr (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .tc (tmr_tc)
  );
  // next-state selection; gov_enable low overrides everything except lockout
  always_comb begin
    st_nxt = st;
    retry_nxt = retry_cnt;
    sess_inc = 1'b0;
    zq = 1'b0;
    clr_cnt = 1'b0;
    case (st)
      S_IDLE:
        if (gov_enable) begin
          st_nxt = S_ATTEST;
          retry_nxt = 2'd0;
        end
      S_ATTEST:
        if (!gov_enable) st_nxt = S_IDLE;
        else if (id_ok) st_nxt = S_KEYREQ;
        else if (tmr_tc) begin
          retry_nxt = retry_inc;
          st_nxt = retry_hit ? S_LOCKOUT : S_ATTEST;
        end
      S_KEYREQ:
        if (!gov_enable) begin
          st_nxt = S_IDLE;
          zq = 1'b1;
        end else if (!id_ok) st_nxt = S_ATTEST;
        else if (key_ok) begin
          st_nxt = S_ACTIVE;
          sess_inc = 1'b1;
          retry_nxt = 2'd0;
          clr_cnt = 1'b1;
        end else if (tmr_tc) begin
          retry_nxt = retry_inc;
          st_nxt = retry_hit ? S_LOCKOUT : S_KEYREQ;
          zq = retry_hit;
        end
      S_ACTIVE: begin
        st_nxt = !gov_enable ? S_IDLE :
                 rpl_inc == RW'(REPLAY_LIMIT) ? S_LOCKOUT :
                 !id_ok ? S_ATTEST :
                 !key_ok ? S_KEYREQ :
                 (pkt_inc == PW'(REKEY_PKTS) || rekey_force) ? S_REKEY : S_ACTIVE;
        zq = st_nxt != S_ACTIVE && st_nxt != S_KEYREQ;
      end
      S_REKEY:
        if (!gov_enable || tmr_tc) begin
          st_nxt = !gov_enable ? S_IDLE : S_LOCKOUT;
          zq = 1'b1;
        end else if (!key_ok) begin
          st_nxt = S_KEYREQ;
          retry_nxt = 2'd0;
        end
      S_LOCKOUT:
        if (clear_fault && !gov_enable) st_nxt = S_IDLE;
      default: st_nxt = S_LOCKOUT;
    endcase
  end
  // state, counters and the zeroize pulse, suppressed if it fired last cycle
  always_ff @(posedge clk)
    if (rst) begin
      st <= S_IDLE;
      retry_cnt <= 2'd0;
      sess_cnt <= 16'd0;
      key_zeroize <= 1'b0;
      pkt_cnt <= '0;
      rpl_cnt <= '0;
    end else begin
      st <= st_nxt;
      retry_cnt <= retry_nxt;
      sess_cnt <= sess_cnt + {15'd0, sess_inc};
      key_zeroize <= zq && !key_zeroize;
      pkt_cnt <= clr_cnt ? '0 : st == S_ACTIVE ? pkt_inc : pkt_cnt;
      rpl_cnt <= clr_cnt ? '0 : st == S_ACTIVE ? rpl_inc : rpl_cnt;
    end
  assign state = st;
  assign id_req = st == S_ATTEST;
  assign key_req = st == S_KEYREQ;
  assign link_en = st == S_ACTIVE;
  assign fault = st == S_LOCKOUT;
endmodule

// File: tb/tb_bithub_link_session_ctrl.sv
// tb_bithub_link_session_ctrl: directed vector table plus timeout sequences for the session controller
module tb_bithub_link_session_ctrl;
  logic clk = 1'b0, rst, gov_enable, id_ok, key_ok, tx_pkt_done, replay_evt, rekey_force, clear_fault;
  logic id_req, key_req, key_zeroize, link_en, fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [15:0] sess_cnt;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic [7:0]  in;
    logic [2:0]  st;
    logic        z;
    logic [1:0]  rt;
    logic [15:0] ss;
  } vec_t;
  vec_t tbl[$];
  bithub_link_session_ctrl #(
    .TIMEOUT_CYC(16), .MAX_RETRY(3), .REKEY_PKTS(4), .REPLAY_LIMIT(2)
  ) dut (
    .clk(clk), .rst(rst), .gov_enable(gov_enable), .id_ok(id_ok), .key_ok(key_ok),
    .tx_pkt_done(tx_pkt_done), .replay_evt(replay_evt), .rekey_force(rekey_force),
    .clear_fault(clear_fault), .id_req(id_req), .key_req(key_req), .key_zeroize(key_zeroize),
    .link_en(link_en), .fault(fault), .state(state), .retry_cnt(retry_cnt), .sess_cnt(sess_cnt)
  );
  always #5 clk = ~clk;
  task automatic cmp(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // inputs packed as {rst, gov_enable, id_ok, key_ok, tx_pkt_done, replay_evt, rekey_force, clear_fault}
  task automatic step(logic [7:0] in);
    {rst, gov_enable, id_ok, key_ok, tx_pkt_done, replay_evt, rekey_force, clear_fault} = in;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [2:0] st, logic z);
    cmp({nm, " state"}, int'(state), int'(st));
    cmp({nm, " id_req"}, int'(id_req), int'(st == 3'd1));
    cmp({nm, " key_req"}, int'(key_req), int'(st == 3'd2));
    cmp({nm, " link_en"}, int'(link_en), int'(st == 3'd3));
    cmp({nm, " fault"}, int'(fault), int'(st == 3'd5));
    cmp({nm, " key_zeroize"}, int'(key_zeroize), int'(z));
  endtask
  task automatic add(logic [7:0] in, logic [2:0] st, logic z, logic [15:0] ss);
    tbl.push_back('{in: in, st: st, z: z, rt: 2'd0, ss: ss});
  endtask
  initial begin
    step(8'b1000_0000);
    add(8'b1000_0000, 0, 0, 0);
    add(8'b0000_0000, 0, 0, 0);
    add(8'b0100_0000, 1, 0, 0);
    add(8'b0100_0000, 1, 0, 0);
    add(8'b0100_0000, 1, 0, 0);
    add(8'b0100_0000, 1, 0, 0);
    add(8'b0110_0000, 2, 0, 0);
    add(8'b0110_0000, 2, 0, 0);
    add(8'b0110_0000, 2, 0, 0);
    add(8'b0110_0000, 2, 0, 0);
    add(8'b0111_0000, 3, 0, 1);
    add(8'b0111_1000, 3, 0, 1);
    add(8'b0111_1000, 3, 0, 1);
    add(8'b0111_1000, 3, 0, 1);
    add(8'b0111_1000, 4, 1, 1);
    add(8'b0111_0000, 4, 0, 1);
    add(8'b0110_0000, 2, 0, 1);
    add(8'b0111_0000, 3, 0, 2);
    add(8'b0111_1000, 3, 0, 2);
    add(8'b0111_1000, 3, 0, 2);
    add(8'b0111_1100, 3, 0, 2);
    add(8'b0111_1100, 5, 1, 2);
    add(8'b0111_0000, 5, 0, 2);
    add(8'b0100_0001, 5, 0, 2);
    add(8'b0000_0000, 5, 0, 2);
    add(8'b0000_0001, 0, 0, 2);
    add(8'b0100_0000, 1, 0, 2);
    add(8'b0110_0000, 2, 0, 2);
    add(8'b0111_0000, 3, 0, 3);
    add(8'b0011_0010, 0, 1, 3);
    add(8'b0000_0000, 0, 0, 3);
    add(8'b0100_0000, 1, 0, 3);
    add(8'b0110_0000, 2, 0, 3);
    add(8'b1110_0000, 0, 0, 0);
    add(8'b0000_0000, 0, 0, 0);
    add(8'b0100_0000, 1, 0, 0);
    add(8'b0110_0000, 2, 0, 0);
    add(8'b0111_0000, 3, 0, 1);
    add(8'b0101_0000, 1, 1, 1);
    add(8'b0110_0000, 2, 0, 1);
    add(8'b0111_0000, 3, 0, 2);
    add(8'b0110_0000, 2, 0, 2);
    add(8'b0111_0000, 3, 0, 3);
    add(8'b0111_0010, 4, 1, 3);
    add(8'b0000_0000, 0, 0, 3);
    foreach (tbl[i]) begin
      step(tbl[i].in);
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].z);
      cmp($sformatf("vec%0d retry_cnt", i), int'(retry_cnt), int'(tbl[i].rt));
      cmp($sformatf("vec%0d sess_cnt", i), int'(sess_cnt), int'(tbl[i].ss));
    end
    step(8'b0100_0000);
    chk("attest_entry", 1, 0);
    for (int n = 1; n <= 48; n++) begin
      step(8'b0100_0000);
      if (n < 48) begin
        chk($sformatf("attest_to%0d", n), 1, 0);
        cmp($sformatf("attest_to%0d retry_cnt", n), int'(retry_cnt), n / 16);
      end else chk("attest_lockout", 5, 0);
    end
    step(8'b0000_0001);
    chk("lock_clear", 0, 0);
    step(8'b0100_0000);
    chk("rk_attest", 1, 0);
    cmp("rk_attest retry_cnt", int'(retry_cnt), 0);
    step(8'b0110_0000);
    chk("rk_keyreq", 2, 0);
    step(8'b0111_0000);
    chk("rk_active", 3, 0);
    cmp("rk_active sess_cnt", int'(sess_cnt), 4);
    step(8'b0111_0010);
    chk("rk_rekey", 4, 1);
    for (int n = 1; n <= 16; n++) begin
      step(8'b0111_0000);
      chk($sformatf("rekey_to%0d", n), n < 16 ? 3'd4 : 3'd5, n == 16);
    end
    step(8'b0111_0000);
    chk("rekey_lock_hold", 5, 0);
    cmp("rekey_lock sess_cnt", int'(sess_cnt), 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
